// File: rtl/uart_pkg.sv
// Shared UART receive constants so the receiver FSM and the SIPO agree on
// frame width and bit order.
package uart_pkg;

    localparam int DATA_BITS      = 5;
    // UART frames put the least-significant data bit on the line first.
    localparam bit UART_LSB_FIRST = 1'b1;

    function automatic int count_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/uart_sipo.sv
// Serial-in/parallel-out shift register for the UART receive datapath:
// one sampled RX bit enters per shift strobe, the assembled word is on dout.
module uart_sipo
    import uart_pkg::*;
#(
    parameter int WIDTH     = DATA_BITS,
    parameter bit LSB_FIRST = UART_LSB_FIRST
) (
    input  logic                               rxin,
    input  logic                               clk,
    input  logic                               shift,
    input  logic                               rst,
    output logic [WIDTH-1:0]                   dout,
    output logic [count_width(WIDTH)-1:0]      count,
    output logic                               full
);

    localparam int CW = count_width(WIDTH);
    localparam logic [CW-1:0] CMAX = CW'(WIDTH);

    generate
        if (WIDTH < 2) begin : g_width_check
            $error("uart_sipo: WIDTH must be >= 2");
        end
    endgenerate

    // LSB-first frames enter at the top so the first bit ends up in dout[0].
    function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] cur,
                                                  input logic             bit_in);
        if (LSB_FIRST)
            return {bit_in, cur[WIDTH-1:1]};
        else
            return {cur[WIDTH-2:0], bit_in};
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dout  <= '0;
            count <= '0;
            full  <= 1'b0;
        end else if (shift) begin
            dout <= shift_in(dout, rxin);
            // Old bits keep falling out past WIDTH; the count just saturates.
            if (count != CMAX) begin
                count <= count + 1'b1;
                full  <= (count == CMAX - 1'b1);
            end
        end
    end

endmodule

// File: tb/tb_uart_sipo.sv
// Bench for uart_sipo: both bit orders driven from one stream and checked
// against a history-of-bits model, plus fixed frame/hold/overflow/reset cases.
module tb_uart_sipo;

    localparam int W  = 5;
    localparam int CW = $clog2(W + 1);

    logic          clk   = 1'b0;
    logic          rst   = 1'b0;
    logic          shift = 1'b0;
    logic          rxin  = 1'b0;
    logic [W-1:0]  dout_l, dout_m;
    logic [CW-1:0] count_l, count_m;
    logic          full_l, full_m;

    int vectors    = 0;
    int miscompares = 0;

    // Newest received bit at index 0, at most W kept.
    bit hist[$];

    uart_sipo #(.WIDTH(W), .LSB_FIRST(1'b1)) dut_lsb (
        .rxin(rxin), .clk(clk), .shift(shift), .rst(rst),
        .dout(dout_l), .count(count_l), .full(full_l)
    );

    uart_sipo #(.WIDTH(W), .LSB_FIRST(1'b0)) dut_msb (
        .rxin(rxin), .clk(clk), .shift(shift), .rst(rst),
        .dout(dout_m), .count(count_m), .full(full_m)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            hist.delete();
        end else if (shift) begin
            hist.push_front(rxin);
            if (hist.size() > W) void'(hist.pop_back());
        end
    end

    function automatic logic [W-1:0] model_dout(input bit lsb_first);
        logic [W-1:0] d;
        d = '0;
        for (int k = 0; k < hist.size(); k++) begin
            if (lsb_first) d[W-1-k] = hist[k];
            else           d[k]     = hist[k];
        end
        return d;
    endfunction

    function automatic int model_count();
        return hist.size();
    endfunction

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        check("dout_lsb",  int'(dout_l),  int'(model_dout(1'b1)));
        check("dout_msb",  int'(dout_m),  int'(model_dout(1'b0)));
        check("count_lsb", int'(count_l), model_count());
        check("count_msb", int'(count_m), model_count());
        check("full_lsb",  int'(full_l),  int'(model_count() == W));
        check("full_msb",  int'(full_m),  int'(model_count() == W));
    end

    task automatic apply(input logic r, input logic s, input logic x);
        rst   = r;
        shift = s;
        rxin  = x;
        @(posedge clk);
        #1;
    endtask

    initial begin
        bit stream[5];
        stream = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};

        // Reset held with shift active and rxin toggling.
        for (int i = 0; i < 3; i++) apply(1'b0, 1'b1, i[0]);
        check("rst_dout",  int'(dout_l),  0);
        check("rst_count", int'(count_l), 0);
        check("rst_full",  int'(full_l),  0);

        // Frame 1,0,1,1,1.
        for (int i = 0; i < 5; i++) apply(1'b1, 1'b1, stream[i]);
        check("frame_dout_lsb", int'(dout_l),  'b11101);
        check("frame_dout_msb", int'(dout_m),  'b10111);
        check("frame_count",    int'(count_l), 5);
        check("frame_full",     int'(full_l),  1);
        check("model_pin_lsb",  int'(model_dout(1'b1)), 'b11101);
        check("model_pin_msb",  int'(model_dout(1'b0)), 'b10111);

        // Hold: rxin toggles (including unknown) with shift low.
        for (int i = 0; i < 4; i++) apply(1'b1, 1'b0, (i == 2) ? 1'bx : i[0]);
        check("hold_dout", int'(dout_l),  'b11101);
        check("hold_count", int'(count_l), 5);

        // Overflow: two more zeros.
        apply(1'b1, 1'b1, 1'b0);
        apply(1'b1, 1'b1, 1'b0);
        check("ovf_dout",  int'(dout_l),  'b00111);
        check("ovf_count", int'(count_l), 5);
        check("ovf_full",  int'(full_l),  1);

        // Mid-frame asynchronous reset between edges.
        apply(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) apply(1'b1, 1'b1, 1'b1);
        check("pre_rst_count", int'(count_l), 3);
        check("pre_rst_dout",  int'(dout_l),  'b11100);
        rst = 1'b0;
        #1;
        check("async_rst_dout",  int'(dout_l),  0);
        check("async_rst_count", int'(count_l), 0);
        check("async_rst_full",  int'(full_l),  0);
        @(posedge clk);
        #1;
        // First shift allowed on the first edge after release.
        apply(1'b1, 1'b1, 1'b1);
        check("post_rst_dout",  int'(dout_l),  'b10000);
        check("post_rst_count", int'(count_l), 1);

        // Randomized traffic with occasional asynchronous reset pulses.
        for (int i = 0; i < 400; i++) begin
            logic s, x;
            s = 1'($urandom_range(0, 3) != 0);
            x = 1'($urandom);
            if ($urandom_range(0, 39) == 0) begin
                rst = 1'b0;
                #2;
                rst = 1'b1;
                @(posedge clk);
                #1;
            end else begin
                apply(1'b1, s, s ? x : 1'bx);
            end
        end

        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
